irda_sip_sched: RTL and testbench
=================================

// Module: irda_sip_sched
// PURPOSE
//  Upstream scheduler for the SIP generator in fast (MIR/FIR) mode. Raises the SIP request
//  (sip_o) on entry to fast mode, every SIP_INTERVAL ticks thereafter, and on software demand.
//  Defers each request until the transmitter is idle, holds off new frames while a SIP runs,
//  and waits for the generator's end indication, with a watchdog.
// PARAMETERS
//  SIP_INTERVAL  500000  ticks between SIPs (tick_i = 1 us strobe -> 500 ms)
//  CNT_W         20      interval counter width; must hold SIP_INTERVAL-1
//  WD_CYCLES     511     clk cycles allowed from sip_o to sip_end_i rise before error
//  WD_W          9       watchdog counter width; must hold WD_CYCLES
// PORTS
//  clk           in   1  clock
//  wb_rst_i      in   1  reset, asynchronous, active-high
//  fast_enable   in   1  1 = MIR/FIR mode active; 0 = scheduler disabled
//  tick_i        in   1  one-cycle time-base strobe from prescaler
//  tx_busy_i     in   1  transmitter is sending a frame; SIP must not start
//  sw_sip_req_i  in   1  one-cycle software request for an immediate SIP
//  sip_end_i     in   1  end-of-SIP level from SIP generator (high for a run of cycles)
//  err_clr_i     in   1  one-cycle clear of sip_err_o
//  sip_o         out  1  SIP request to generator; registered single-cycle pulse
//  tx_hold_o     out  1  registered; blocks transmitter frame start
//  sip_err_o     out  1  sticky: watchdog expired without sip_end_i
// BEHAVIOUR
//  Reset: state IDLE, interval cnt 0, wd 0, sw_flag 0, sip_o 0, tx_hold_o 0, sip_err_o 0.
//  States: IDLE, PEND, REQ, WAIT_END. tx_hold_o = 1 in PEND/REQ/WAIT_END, else 0 (registered).
//  IDLE: cnt += 1 on tick_i; on tick_i with cnt == SIP_INTERVAL-1 -> PEND, cnt <= 0.
//        sw_sip_req_i or sw_flag -> PEND (sw_flag cleared). Expiry and sw request in
//        the same cycle -> one SIP only.
//  PEND: cnt frozen. When tx_busy_i == 0 -> REQ; else stay (arbitrarily long).
//  REQ: sip_o = 1 for exactly this one cycle (sip_o low in every other state, so the
//       generator's rising-edge detector always sees a low-to-high transition); wd <= 0;
//       -> WAIT_END.
//  WAIT_END: wd += 1 each clk. Rising edge of sip_end_i (registered prev-sample, 1-cycle
//       detect latency) -> IDLE, cnt <= 0. wd == WD_CYCLES without edge -> sip_err_o <= 1,
//       -> IDLE, cnt <= 0. Edge and timeout in the same cycle: edge wins, no error.
//  sw_sip_req_i in PEND: absorbed, no extra SIP. In REQ/WAIT_END: sets sw_flag, so exactly one
//       further SIP is issued right after return to IDLE. sw_flag is one deep.
//  sip_end_i edges seen outside WAIT_END are ignored.
//  fast_enable low: synchronous force to IDLE, cnt 0, wd 0, sw_flag 0, sip_o 0, tx_hold_o 0.
//       All requests ignored. sip_err_o is kept.
//  fast_enable rise (0->1, registered detect): -> PEND next cycle, so a SIP is issued at once.
//  Disable mid-SIP (REQ/WAIT_END): abort as above. The generator finishes on its own.
//  sip_err_o: set by watchdog, cleared by err_clr_i. Set wins if both occur in the same cycle.
//  wb_rst_i at any time returns all state to the reset values asynchronously.
//  Counters never wrap: cnt clears at expiry, wd stops at WD_CYCLES.
// TESTING  (SIP_INTERVAL=10, WD_CYCLES=511; generator model: sip_end_i high 71 cycles,
//          starting 350 clk after sip_o)
//  fast_enable 0->1, tx_busy 0 -> sip_o single pulse 2-3 clk later; tx_hold_o high until
//      1 clk after sip_end_i rise; next sip_o on the 10th tick after that.
//  Interval expires with tx_busy_i=1 for 40 clk -> tx_hold_o=1, sip_o stays 0 until 1 clk after
//      tx_busy_i falls, then exactly one pulse.
//  sw_sip_req_i in IDLE cycle N -> sip_o at N+2. sw_sip_req_i twice during WAIT_END -> exactly
//      one extra SIP after completion.
//  sip_end_i held 0 -> sip_err_o=1 at 511 clk after sip_o, return to IDLE; err_clr_i -> 0.
//      Simultaneous err_clr_i and timeout -> sip_err_o stays 1.
//  fast_enable drop in WAIT_END -> next cycle tx_hold_o=0, state IDLE, no sip_o while
//      disabled; re-enable -> immediate SIP.
//  wb_rst_i pulse mid-PEND -> all outputs 0 immediately, no sip_o until expiry or request.

Source files
------------

// File: rtl/irda_sip_sched_if.sv
// Signal bundle between the fast-mode SIP scheduler and the host, transmitter and SIP generator.
// The master side drives the scheduler's inputs; the slave modport is the scheduler itself.
interface irda_sip_sched_if;
  logic fast_enable;
  logic tick_i;
  logic tx_busy_i;
  logic sw_sip_req_i;
  logic sip_end_i;
  logic err_clr_i;
  logic sip_o;
  logic tx_hold_o;
  logic sip_err_o;

  modport master (
    output fast_enable, tick_i, tx_busy_i, sw_sip_req_i, sip_end_i, err_clr_i,
    input  sip_o, tx_hold_o, sip_err_o
  );

  modport slave (
    input  fast_enable, tick_i, tx_busy_i, sw_sip_req_i, sip_end_i, err_clr_i,
    output sip_o, tx_hold_o, sip_err_o
  );
endinterface

// File: rtl/irda_sip_sched.sv
// Fast-mode SIP scheduler: requests a SIP on mode entry, periodically and on software demand,
// waits for an idle transmitter, then waits for the generator's end indication under a watchdog.
module irda_sip_sched #(
  parameter int unsigned SIP_INTERVAL = 500000,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned WD_CYCLES    = 511,
  parameter int unsigned WD_W         = 9
) (
  input logic             clk,
  input logic             wb_rst_i,
  irda_sip_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPend, StReq, StWaitEnd} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SIP_INTERVAL - 1);
  localparam logic [WD_W-1:0]  WdLast  = WD_W'(WD_CYCLES);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [WD_W-1:0]  r_wd, w_wd_d;
  logic             r_sw_flag, w_sw_flag_d;
  logic             r_sip, r_hold, r_err;
  logic             r_fe_prev, r_end_prev;
  logic             w_fe_rise, w_end_rise, w_expire, w_timeout, w_err_set;

  always_comb begin
    w_fe_rise   = bus.fast_enable & ~r_fe_prev;
    w_end_rise  = bus.sip_end_i & ~r_end_prev;
    w_expire    = bus.tick_i && (r_cnt == CntLast);
    w_timeout   = (r_wd == WdLast);
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_wd_d      = r_wd;
    w_sw_flag_d = r_sw_flag;
    w_err_set   = 1'b0;

    if (!bus.fast_enable) begin
      w_state_d   = StIdle;
      w_cnt_d     = '0;
      w_wd_d      = '0;
      w_sw_flag_d = 1'b0;
    end else if (w_fe_rise) begin
      w_state_d = StPend;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_expire) begin
            w_cnt_d   = '0;
            w_state_d = StPend;
          end else if (bus.tick_i) begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
          // Expiry and a software request together still yield a single SIP.
          if (bus.sw_sip_req_i || r_sw_flag) begin
            w_state_d   = StPend;
            w_sw_flag_d = 1'b0;
          end
        end
        StPend: begin
          if (!bus.tx_busy_i) w_state_d = StReq;
        end
        StReq: begin
          w_wd_d    = '0;
          w_state_d = StWaitEnd;
          if (bus.sw_sip_req_i) w_sw_flag_d = 1'b1;
        end
        StWaitEnd: begin
          if (bus.sw_sip_req_i) w_sw_flag_d = 1'b1;
          // The end edge takes priority over a coincident watchdog expiry.
          if (w_end_rise) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else if (w_timeout) begin
            w_err_set = 1'b1;
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else begin
            w_wd_d = r_wd + WD_W'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_wd       <= '0;
      r_sw_flag  <= 1'b0;
      r_sip      <= 1'b0;
      r_hold     <= 1'b0;
      r_err      <= 1'b0;
      // Preset high so an enable already asserted across reset is not seen as a fresh rise.
      r_fe_prev  <= 1'b1;
      r_end_prev <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_wd       <= w_wd_d;
      r_sw_flag  <= w_sw_flag_d;
      r_sip      <= (w_state_d == StReq);
      r_hold     <= (w_state_d != StIdle);
      r_err      <= w_err_set | (r_err & ~bus.err_clr_i);
      r_fe_prev  <= bus.fast_enable;
      r_end_prev <= bus.sip_end_i;
    end
  end

  assign bus.sip_o     = r_sip;
  assign bus.tx_hold_o = r_hold;
  assign bus.sip_err_o = r_err;

endmodule

// File: tb/tb_irda_sip_sched.sv
// Directed bench for irda_sip_sched with a small SIP generator model
// (sip_end_i high for 71 cycles, rising 350 cycles after each sip_o).
module tb_irda_sip_sched;
  logic clk = 1'b0;
  logic wb_rst_i;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   gen_en  = 1'b0;

  irda_sip_sched_if bus ();

  irda_sip_sched #(
    .SIP_INTERVAL(10),
    .CNT_W       (4),
    .WD_CYCLES   (511),
    .WD_W        (9)
  ) u_dut (
    .clk     (clk),
    .wb_rst_i(wb_rst_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin : gen_model
    int   pend;
    int   high;
    logic lvl;
    pend = 0;
    high = 0;
    lvl  = 1'b0;
    bus.sip_end_i = 1'b0;
    forever begin
      @(negedge clk);
      if (high > 0) begin
        high--;
        if (high == 0) lvl = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          lvl  = 1'b1;
          high = 71;
        end
      end
      if (gen_en && bus.sip_o === 1'b1) pend = 350;
      #1 bus.sip_end_i = lvl;
    end
  end

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic sw_pulse();
    bus.sw_sip_req_i = 1'b1;
    step();
    bus.sw_sip_req_i = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_i = 1'b1;
      step();
      bus.tick_i = 1'b0;
      step();
    end
  endtask

  // Steps until tx_hold_o drops (bounded); k = steps taken, p = sip_o pulses seen meanwhile.
  task automatic wait_done(output int k, output int p);
    k = 0;
    p = 0;
    while (k < 1000) begin
      step();
      k++;
      if (bus.sip_o === 1'b1) p++;
      if (bus.tx_hold_o === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    n_total++;
    if ({bus.sip_o, bus.tx_hold_o, bus.sip_err_o} !== 3'b000) begin
      $display("FAIL reset_outputs: got %b, expected 000", {bus.sip_o, bus.tx_hold_o, bus.sip_err_o});
    end else n_pass++;
    wb_rst_i = 1'b0;
    sw_pulse();
    tick_n(12);
    n_total++;
    if ({bus.sip_o, bus.tx_hold_o} !== 2'b00) begin
      $display("FAIL disabled_idle: got %b, expected 00", {bus.sip_o, bus.tx_hold_o});
    end else n_pass++;
  endtask

  task automatic test_enable_rise();
    int k, p;
    gen_en = 1'b1;
    bus.fast_enable = 1'b1;
    step();
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b10) begin
      $display("FAIL rise_pend: got %b, expected 10", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL rise_sip: got %b, expected 1", bus.sip_o);
    else n_pass++;
    wait_done(k, p);
    n_total++;
    if (k !== 351 || p !== 0 || bus.sip_end_i !== 1'b1) begin
      $display("FAIL rise_done: got k=%0d p=%0d end=%b, expected k=351 p=0 end=1",
               k, p, bus.sip_end_i);
    end else n_pass++;
    repeat (75) step();
    tick_n(9);
    n_total++;
    if (bus.tx_hold_o !== 1'b0) $display("FAIL interval_9th: got hold=%b, expected 0", bus.tx_hold_o);
    else n_pass++;
    bus.tick_i = 1'b1;
    step();
    bus.tick_i = 1'b0;
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b10) begin
      $display("FAIL interval_10th: got %b, expected 10", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL interval_sip: got %b, expected 1", bus.sip_o);
    else n_pass++;
    wait_done(k, p);
    n_total++;
    if (k !== 351 || p !== 0) $display("FAIL interval_done: got k=%0d p=%0d, expected 351 0", k, p);
    else n_pass++;
    repeat (75) step();
  endtask

  task automatic test_busy_defer();
    int k, p;
    bus.tx_busy_i = 1'b1;
    tick_n(10);
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b10) begin
      $display("FAIL busy_pend: got %b, expected 10", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    p = 0;
    repeat (40) begin
      step();
      if (bus.sip_o === 1'b1) p++;
    end
    n_total++;
    if (p !== 0 || bus.tx_hold_o !== 1'b1) begin
      $display("FAIL busy_hold: got p=%0d hold=%b, expected 0 1", p, bus.tx_hold_o);
    end else n_pass++;
    bus.tx_busy_i = 1'b0;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL busy_release: got %b, expected 1", bus.sip_o);
    else n_pass++;
    wait_done(k, p);
    n_total++;
    if (k !== 351 || p !== 0) $display("FAIL busy_done: got k=%0d p=%0d, expected 351 0", k, p);
    else n_pass++;
    repeat (75) step();
  endtask

  task automatic test_sw_req();
    int k, p;
    sw_pulse();
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b10) begin
      $display("FAIL sw_pend: got %b, expected 10", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL sw_sip_n2: got %b, expected 1", bus.sip_o);
    else n_pass++;
    repeat (5) step();
    sw_pulse();
    repeat (10) step();
    sw_pulse();
    wait_done(k, p);
    n_total++;
    if (k !== 334 || p !== 0) $display("FAIL sw_first_done: got k=%0d p=%0d, expected 334 0", k, p);
    else n_pass++;
    step();
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b10) begin
      $display("FAIL sw_extra_pend: got %b, expected 10", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL sw_extra_sip: got %b, expected 1", bus.sip_o);
    else n_pass++;
    wait_done(k, p);
    n_total++;
    if (k !== 351 || p !== 0) $display("FAIL sw_extra_done: got k=%0d p=%0d, expected 351 0", k, p);
    else n_pass++;
    p = 0;
    repeat (100) begin
      step();
      if (bus.sip_o === 1'b1 || bus.tx_hold_o === 1'b1) p++;
    end
    n_total++;
    if (p !== 0) $display("FAIL sw_only_one_extra: got %0d busy cycles, expected 0", p);
    else n_pass++;
  endtask

  task automatic test_collide();
    int k, p;
    tick_n(9);
    bus.tick_i = 1'b1;
    bus.sw_sip_req_i = 1'b1;
    step();
    bus.tick_i = 1'b0;
    bus.sw_sip_req_i = 1'b0;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL collide_sip: got %b, expected 1", bus.sip_o);
    else n_pass++;
    wait_done(k, p);
    repeat (100) begin
      step();
      if (bus.sip_o === 1'b1) p++;
    end
    n_total++;
    if (k !== 351 || p !== 0) $display("FAIL collide_single: got k=%0d p=%0d, expected 351 0", k, p);
    else n_pass++;
    bus.tx_busy_i = 1'b1;
    sw_pulse();
    step();
    sw_pulse();
    bus.tx_busy_i = 1'b0;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL pend_absorb_sip: got %b, expected 1", bus.sip_o);
    else n_pass++;
    wait_done(k, p);
    repeat (100) begin
      step();
      if (bus.sip_o === 1'b1) p++;
    end
    n_total++;
    if (k !== 351 || p !== 0) $display("FAIL pend_absorb: got k=%0d p=%0d, expected 351 0", k, p);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int k;
    gen_en = 1'b0;
    sw_pulse();
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL wd_sip: got %b, expected 1", bus.sip_o);
    else n_pass++;
    k = 0;
    while (k < 600 && bus.sip_err_o !== 1'b1) begin
      step();
      k++;
    end
    n_total++;
    if (k < 511 || k > 513 || bus.tx_hold_o !== 1'b0) begin
      $display("FAIL wd_timeout: got k=%0d hold=%b, expected k in 511..513 hold=0", k, bus.tx_hold_o);
    end else n_pass++;
    bus.err_clr_i = 1'b1;
    step();
    bus.err_clr_i = 1'b0;
    n_total++;
    if (bus.sip_err_o !== 1'b0) $display("FAIL wd_clear: got %b, expected 0", bus.sip_err_o);
    else n_pass++;
    sw_pulse();
    step();
    bus.err_clr_i = 1'b1;
    k = 0;
    while (k < 600 && bus.sip_err_o !== 1'b1) begin
      step();
      k++;
    end
    bus.err_clr_i = 1'b0;
    step();
    step();
    n_total++;
    if (bus.sip_err_o !== 1'b1 || k >= 600) begin
      $display("FAIL wd_set_wins: got err=%b k=%0d, expected err=1 k<600", bus.sip_err_o, k);
    end else n_pass++;
    bus.err_clr_i = 1'b1;
    step();
    bus.err_clr_i = 1'b0;
    n_total++;
    if (bus.sip_err_o !== 1'b0) $display("FAIL wd_clear2: got %b, expected 0", bus.sip_err_o);
    else n_pass++;
  endtask

  task automatic test_disable();
    int k, p;
    sw_pulse();
    step();
    repeat (5) step();
    bus.fast_enable = 1'b0;
    step();
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b00) begin
      $display("FAIL dis_abort: got %b, expected 00", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    p = 0;
    for (int i = 0; i < 30; i++) begin
      bus.sw_sip_req_i = (i == 3);
      bus.tick_i = (i % 2 == 0);
      step();
      if (bus.sip_o === 1'b1 || bus.tx_hold_o === 1'b1) p++;
    end
    bus.sw_sip_req_i = 1'b0;
    bus.tick_i = 1'b0;
    n_total++;
    if (p !== 0) $display("FAIL dis_ignored: got %0d active cycles, expected 0", p);
    else n_pass++;
    bus.fast_enable = 1'b1;
    step();
    step();
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b11) begin
      $display("FAIL reen_sip: got %b, expected 11", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    k = 0;
    while (k < 600 && bus.sip_err_o !== 1'b1) begin
      step();
      k++;
    end
    bus.fast_enable = 1'b0;
    repeat (3) step();
    n_total++;
    if (bus.sip_err_o !== 1'b1 || bus.tx_hold_o !== 1'b0) begin
      $display("FAIL dis_err_kept: got err=%b hold=%b, expected 1 0", bus.sip_err_o, bus.tx_hold_o);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_pend();
    int p;
    bus.tx_busy_i = 1'b1;
    bus.fast_enable = 1'b1;
    step();
    repeat (3) step();
    n_total++;
    if ({bus.tx_hold_o, bus.sip_o} !== 2'b10) begin
      $display("FAIL pre_reset_pend: got %b, expected 10", {bus.tx_hold_o, bus.sip_o});
    end else n_pass++;
    #2 wb_rst_i = 1'b1;
    #1;
    n_total++;
    if ({bus.sip_o, bus.tx_hold_o, bus.sip_err_o} !== 3'b000) begin
      $display("FAIL async_reset: got %b, expected 000", {bus.sip_o, bus.tx_hold_o, bus.sip_err_o});
    end else n_pass++;
    step();
    wb_rst_i = 1'b0;
    bus.tx_busy_i = 1'b0;
    p = 0;
    repeat (20) begin
      step();
      if (bus.sip_o === 1'b1 || bus.tx_hold_o === 1'b1) p++;
    end
    tick_n(9);
    n_total++;
    if (p !== 0 || bus.tx_hold_o !== 1'b0) begin
      $display("FAIL post_reset_quiet: got p=%0d hold=%b, expected 0 0", p, bus.tx_hold_o);
    end else n_pass++;
    bus.tick_i = 1'b1;
    step();
    bus.tick_i = 1'b0;
    step();
    n_total++;
    if (bus.sip_o !== 1'b1) $display("FAIL post_reset_expiry: got %b, expected 1", bus.sip_o);
    else n_pass++;
  endtask

  initial begin
    wb_rst_i         = 1'b1;
    bus.fast_enable  = 1'b0;
    bus.tick_i       = 1'b0;
    bus.tx_busy_i    = 1'b0;
    bus.sw_sip_req_i = 1'b0;
    bus.err_clr_i    = 1'b0;
    repeat (3) step();
    test_reset();
    test_enable_rise();
    test_busy_defer();
    test_sw_req();
    test_collide();
    test_watchdog();
    test_disable();
    test_reset_mid_pend();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
